// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
//   Matrix keypad scanner with column synchroniser and press/release debounce.
//   Rows are driven active-low one at a time. Active-low columns are
//   synchronised through two flops. A single pressed key must hold the same
//   column pattern for DEB_CYCLES cycles before it is accepted. A release is
//   accepted only after DEB_CYCLES consecutive all-ones cycles.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   cols_n     raw column inputs, active-low, asynchronous to clk
//   rows_n     row drive, one-hot-low
//   key_row    one-hot row of the last accepted key
//   key_col    one-hot column of the last accepted key
//   key_code   row_idx*NCOLS + col_idx of the last accepted key
//   key_valid  single-cycle pulse per accepted press
//   key_held   high from acceptance until debounced release
module keypad_scan_debounce #(
    parameter int NROWS      = 4,
    parameter int NCOLS      = 4,
    parameter int SCAN_DIV   = 16,
    parameter int DEB_CYCLES = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NCOLS-1:0]                 cols_n,
    output logic [NROWS-1:0]                 rows_n,
    output logic [NROWS-1:0]                 key_row,
    output logic [NCOLS-1:0]                 key_col,
    output logic [$clog2(NROWS*NCOLS)-1:0]   key_code,
    output logic                             key_valid,
    output logic                             key_held
);

    localparam int ROW_W   = $clog2(NROWS);
    localparam int COL_W   = $clog2(NCOLS);
    localparam int DWELL_W = $clog2(SCAN_DIV);
    localparam int DEB_W   = $clog2(DEB_CYCLES);
    localparam int CODE_W  = $clog2(NROWS*NCOLS);

    localparam logic [NROWS-1:0]   ONE_ROW   = NROWS'(1);
    localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(NROWS - 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Registered state
    logic [NCOLS-1:0]  sync1;
    logic [NCOLS-1:0]  cols_s;
    state_t            state;
    logic [ROW_W-1:0]  row_idx;
    logic [DWELL_W-1:0] dwell;
    logic [DEB_W-1:0]  deb;
    logic [NCOLS-1:0]  cap_pat;

    // Next-state values
    state_t            state_next;
    logic [ROW_W-1:0]  row_idx_next;
    logic [DWELL_W-1:0] dwell_next;
    logic [DEB_W-1:0]  deb_next;
    logic [NCOLS-1:0]  cap_pat_next;
    logic [NROWS-1:0]  key_row_next;
    logic [NCOLS-1:0]  key_col_next;
    logic [CODE_W-1:0] key_code_next;
    logic              key_valid_next;
    logic              key_held_next;

    // Helpers
    logic [NCOLS-1:0]  cols_low;
    logic              one_hot_low;
    logic              all_ones;
    logic [ROW_W-1:0]  row_after;
    logic [COL_W-1:0]  cap_col_idx;

    // Two-flop synchroniser. It resets to all-ones so that "no key" is what
    // the scanner sees while the chain refills after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '1;
            cols_s <= '1;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the values
            // from before this edge, giving a true two-stage chain.
            sync1  <= cols_n;
            cols_s <= sync1;
        end
    end

    assign cols_low    = ~cols_s;
    // Exactly one column low: non-zero and a power of two.
    assign one_hot_low = (cols_low != '0) && ((cols_low & (cols_low - NCOLS'(1))) == '0);
    assign all_ones    = (cols_s == '1);
    assign row_after   = (row_idx == ROW_LAST) ? '0 : row_idx + ROW_W'(1);

    // Column index of the captured (one-hot-low) pattern.
    always_comb begin
        cap_col_idx = '0;
        for (int c = 0; c < NCOLS; c++) begin
            if (!cap_pat[c]) cap_col_idx = COL_W'(c);
        end
    end

    // Next-state and output logic.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_next     = state;
        row_idx_next   = row_idx;
        dwell_next     = dwell;
        deb_next       = deb;
        cap_pat_next   = cap_pat;
        key_row_next   = key_row;
        key_col_next   = key_col;
        key_code_next  = key_code;
        key_valid_next = 1'b0;
        key_held_next  = key_held;

        unique case (state)
            SCAN: begin
                if (dwell == DWELL_MAX) begin
                    dwell_next = '0;
                    if (one_hot_low) begin
                        // Freeze the row and start debouncing this pattern.
                        cap_pat_next = cols_s;
                        deb_next     = '0;
                        state_next   = DEBOUNCE;
                    end else begin
                        // No key, or several keys (possible ghosting): move on.
                        row_idx_next = row_after;
                    end
                end else begin
                    dwell_next = dwell + DWELL_W'(1);
                end
            end

            DEBOUNCE: begin
                if (cols_s != cap_pat) begin
                    state_next   = SCAN;
                    row_idx_next = row_after;
                    dwell_next   = '0;
                end else if (deb == DEB_MAX) begin
                    key_valid_next = 1'b1;
                    key_held_next  = 1'b1;
                    key_row_next   = ONE_ROW << row_idx;
                    key_col_next   = ~cap_pat;
                    key_code_next  = CODE_W'(row_idx) * CODE_W'(NCOLS) + CODE_W'(cap_col_idx);
                    state_next     = HELD;
                end else begin
                    deb_next = deb + DEB_W'(1);
                end
            end

            HELD: begin
                // Any other non-idle pattern is ignored: one pulse per press.
                if (all_ones) begin
                    deb_next   = '0;
                    state_next = RELEASE;
                end
            end

            RELEASE: begin
                if (!all_ones) begin
                    state_next = HELD;
                end else if (deb == DEB_MAX) begin
                    key_held_next = 1'b0;
                    state_next    = SCAN;
                    row_idx_next  = row_after;
                    dwell_next    = '0;
                end else begin
                    deb_next = deb + DEB_W'(1);
                end
            end

            default: begin
                state_next = SCAN;
            end
        endcase
    end

    // State register. rows_n is registered so the pins never glitch while
    // the row index changes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            row_idx   <= '0;
            dwell     <= '0;
            deb       <= '0;
            cap_pat   <= '1;
            rows_n    <= ~ONE_ROW;
            key_row   <= '0;
            key_col   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            row_idx   <= row_idx_next;
            dwell     <= dwell_next;
            deb       <= deb_next;
            cap_pat   <= cap_pat_next;
            rows_n    <= ~(ONE_ROW << row_idx_next);
            key_row   <= key_row_next;
            key_col   <= key_col_next;
            key_code  <= key_code_next;
            key_valid <= key_valid_next;
            key_held  <= key_held_next;
        end
    end

endmodule
